// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline-boundary register.
// Carries a packed payload plus a sticky side field between two stages.
// It also provides a payload valid bit, an exception flush, a configurable
// position in the global stall vector, and a saturating bubble counter.
module pipe_stage_reg #(
   parameter int                DATA_W       = 32,
   parameter int                KEEP_W       = 1,
   parameter int                STALL_W      = 6,
   parameter int                STAGE        = 2,
   parameter logic [DATA_W-1:0] BUBBLE_VAL   = '0,
   parameter bit                ZERO_INVALID = 1'b1,
   parameter int                CNT_W        = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [KEEP_W-1:0]  in_keep,
   input  logic               cnt_clr,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic [KEEP_W-1:0]  out_keep,
   output logic [CNT_W-1:0]   bubble_cnt
);

   // Stage-local stall decode. The last stage has no downstream stage, so
   // its downstream stall always reads as NoStop.
   logic w_s_up;
   logic w_s_dn;

   assign w_s_up = stall[STAGE];

   generate
      if (STAGE == STALL_W - 1) begin : g_top_stage
         assign w_s_dn = 1'b0;
      end else begin : g_mid_stage
         assign w_s_dn = stall[STAGE+1];
      end
   endgenerate

   // A bubble occurs when upstream is stalled and downstream is not.
   // Flush overrides the bubble, so a flush cycle is never counted.
   logic w_bubble;
   assign w_bubble = !flush && w_s_up && !w_s_dn;

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [KEEP_W-1:0] r_keep;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_nxt_valid;
   logic [DATA_W-1:0] w_nxt_data;
   logic [KEEP_W-1:0] w_nxt_keep;
   logic [CNT_W-1:0]  w_nxt_cnt;
   logic              w_cnt_sat;

   // Next payload state, by priority: flush, bubble, load, then hold.
   // The load branch also absorbs a non-monotonic stall vector, where the
   // upstream stage runs but the downstream stage is stalled.
   always_comb begin
      w_nxt_valid = r_valid;
      w_nxt_data  = r_data;
      w_nxt_keep  = r_keep;
      if (flush) begin
         w_nxt_valid = 1'b0;
         w_nxt_data  = BUBBLE_VAL;
         w_nxt_keep  = '0;
      end else if (w_s_up && !w_s_dn) begin
         // The sticky field deliberately survives the bubble.
         w_nxt_valid = 1'b0;
         w_nxt_data  = BUBBLE_VAL;
      end else if (!w_s_up) begin
         w_nxt_valid = in_valid;
         w_nxt_keep  = in_keep;
         if (!in_valid && ZERO_INVALID)
            w_nxt_data = BUBBLE_VAL;
         else
            w_nxt_data = in_data;
      end
   end

   // Next counter value. A clear wins over an increment in the same cycle,
   // and the count sticks at all-ones instead of wrapping.
   assign w_cnt_sat = &r_cnt;

   always_comb begin
      w_nxt_cnt = r_cnt;
      if (cnt_clr)
         w_nxt_cnt = '0;
      else if (w_bubble && !w_cnt_sat)
         w_nxt_cnt = r_cnt + CNT_W'(1);
   end

   // Payload registers, with reset to the bubble encoding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= BUBBLE_VAL;
         r_keep  <= '0;
      end else begin
         r_valid <= w_nxt_valid;
         r_data  <= w_nxt_data;
         r_keep  <= w_nxt_keep;
      end
   end

   // Bubble counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else        r_cnt <= w_nxt_cnt;
   end

   assign out_valid  = r_valid;
   assign out_data   = r_data;
   assign out_keep   = r_keep;
   assign bubble_cnt = r_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vectors with a queue-based scoreboard.
// Three instances share their inputs: the defaults, CNT_W=4, and STAGE=5.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  stall = '0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic [0:0]  in_keep = '0;
   logic        cnt_clr = 1'b0;

   logic        m_valid, c_valid, t_valid;
   logic [31:0] m_data, c_data, t_data;
   logic [0:0]  m_keep, c_keep, t_keep;
   logic [15:0] m_cnt, t_cnt;
   logic [3:0]  c_cnt;

   always #5 clk = ~clk;

   pipe_stage_reg u_main (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep),
      .cnt_clr(cnt_clr), .out_valid(m_valid), .out_data(m_data),
      .out_keep(m_keep), .bubble_cnt(m_cnt));

   pipe_stage_reg #(.CNT_W(4)) u_cnt4 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep),
      .cnt_clr(cnt_clr), .out_valid(c_valid), .out_data(c_data),
      .out_keep(c_keep), .bubble_cnt(c_cnt));

   pipe_stage_reg #(.STAGE(5)) u_top (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep),
      .cnt_clr(cnt_clr), .out_valid(t_valid), .out_data(t_data),
      .out_keep(t_keep), .bubble_cnt(t_cnt));

   // m[0]: main payload, m[1]: main counter, m[2]: CNT_W=4 counter,
   // m[3]: STAGE=5 valid/data/counter
   typedef struct {
      string       tag;
      logic [3:0]  m;
      logic        v;
      logic [31:0] d;
      logic        k;
      logic [15:0] c;
      logic [3:0]  c4;
      logic        tv;
      logic [31:0] td;
      logic [15:0] tc;
   } exp_t;

   exp_t q[$];
   exp_t nx;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check(input exp_t e);
      if (e.m[0]) begin
         cmp({e.tag, " out_valid"}, 32'(m_valid), 32'(e.v));
         cmp({e.tag, " out_data"}, m_data, e.d);
         cmp({e.tag, " out_keep"}, 32'(m_keep), 32'(e.k));
      end
      if (e.m[1]) cmp({e.tag, " bubble_cnt"}, 32'(m_cnt), 32'(e.c));
      if (e.m[2]) cmp({e.tag, " cnt4"}, 32'(c_cnt), 32'(e.c4));
      if (e.m[3]) begin
         cmp({e.tag, " top out_valid"}, 32'(t_valid), 32'(e.tv));
         cmp({e.tag, " top out_data"}, t_data, e.td);
         cmp({e.tag, " top bubble_cnt"}, 32'(t_cnt), 32'(e.tc));
      end
   endtask

   // Monitor: one scoreboard entry per active edge that stimulus issued.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) check(q.pop_front());
      end
   end

   task automatic drive(input string tag, input logic [5:0] st, input logic fl,
                        input logic iv, input logic [31:0] id, input logic ik,
                        input logic clr);
      @(negedge clk);
      stall = st; flush = fl; in_valid = iv; in_data = id; in_keep = ik; cnt_clr = clr;
      nx = '{tag: tag, m: 4'b0, v: 1'b0, d: 32'h0, k: 1'b0, c: 16'h0,
             c4: 4'h0, tv: 1'b0, td: 32'h0, tc: 16'h0};
   endtask

   task automatic xm(input logic v, input logic [31:0] d, input logic k, input logic [15:0] c);
      nx.m[1:0] = 2'b11; nx.v = v; nx.d = d; nx.k = k; nx.c = c;
   endtask

   task automatic x4(input logic [3:0] c4);
      nx.m[2] = 1'b1; nx.c4 = c4;
   endtask

   task automatic xt(input logic tv, input logic [31:0] td, input logic [15:0] tc);
      nx.m[3] = 1'b1; nx.tv = tv; nx.td = td; nx.tc = tc;
   endtask

   task automatic push();
      q.push_back(nx);
   endtask

   task automatic check_reset(input string tag);
      nx.tag = tag; nx.m = 4'b1111;
      nx.v = 1'b0; nx.d = 32'h0; nx.k = 1'b0; nx.c = 16'h0;
      nx.c4 = 4'h0; nx.tv = 1'b0; nx.td = 32'h0; nx.tc = 16'h0;
      check(nx);
   endtask

   task automatic do_reset();
      @(negedge clk);
      stall = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '0; cnt_clr = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2;
      check_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset asserted between edges while loading.
      drive("pre-reset load", 6'b000000, 0, 1, 32'h1234_5678, 1, 0);
      xm(1, 32'h1234_5678, 1, 0); push();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("async reset");
      @(posedge clk);
      #1 check_reset("reset held over edge");
      @(negedge clk);
      rst_n = 1'b1;

      // Plain load.
      drive("load", 6'b000000, 0, 1, 32'hDEAD_BEEF, 1, 0);
      xm(1, 32'hDEAD_BEEF, 1, 0); xt(1, 32'hDEAD_BEEF, 0); push();

      // Bubble: sticky field held, counter increments.
      drive("bubble", 6'b000111, 0, 1, 32'h0000_AAAA, 0, 0);
      xm(0, 32'h0, 1, 1); push();
      for (int i = 0; i < 3; i++) begin
         drive("hold", 6'b001111, 0, 1, 32'h0000_1111, 0, 0);
         xm(0, 32'h0, 1, 1); push();
      end

      // Flush over a full stall, then flush during a bubble-shaped stall.
      drive("reload", 6'b000000, 0, 1, 32'hCAFE_F00D, 1, 0);
      xm(1, 32'hCAFE_F00D, 1, 1); push();
      drive("flush over stall", 6'b001111, 1, 1, 32'h0000_2222, 1, 0);
      xm(0, 32'h0, 0, 1); push();
      drive("reload2", 6'b000000, 0, 1, 32'h0BAD_F00D, 1, 0);
      xm(1, 32'h0BAD_F00D, 1, 1); push();
      drive("flush over bubble", 6'b000111, 1, 1, 32'h0000_3333, 1, 0);
      xm(0, 32'h0, 0, 1); push();

      // Counter saturation on CNT_W=4, then clear beating an increment.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive("bubble run", 6'b000111, 0, 0, 32'h0, 0, 0);
         xm(0, 32'h0, 0, 16'(i + 1));
         x4((i + 1 > 15) ? 4'hF : 4'(i + 1));
         push();
      end
      drive("clear with bubble", 6'b000111, 0, 0, 32'h0, 0, 1);
      xm(0, 32'h0, 0, 0); x4(4'h0); push();
      drive("bubble after clear", 6'b000111, 0, 0, 32'h0, 0, 0);
      xm(0, 32'h0, 0, 1); x4(4'h1); push();

      // Invalid load is squashed to the bubble value; top stage bubbles
      // with no downstream stall bit.
      do_reset();
      drive("invalid load", 6'b000000, 0, 0, 32'h0000_5555, 1, 0);
      xm(0, 32'h0, 1, 0); xt(0, 32'h0, 0); push();
      drive("top load", 6'b000000, 0, 1, 32'h0000_0012, 0, 0);
      xm(1, 32'h12, 0, 0); xt(1, 32'h12, 0); push();
      drive("top bubble", 6'b100000, 0, 1, 32'h0000_0034, 0, 0);
      xm(1, 32'h34, 0, 0); xt(0, 32'h0, 1); push();

      repeat (3) @(posedge clk);
      #2;
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
